// File: rtl/gs232c_fetch_buf.sv
// gs232c_fetch_buf: circular instruction fetch buffer between the k-word selector and decode.
// Optional macro GS232C_FETCH_BUF_BYPASS_EN lets incoming words reach the decode slots in the
// same cycle they arrive.
module gs232c_fetch_buf #(
    parameter int W     = 32,
    parameter int K     = 4,
    parameter int D     = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [$clog2(K+1)-1:0]     in_cnt,
    input  logic [W*K-1:0]             in_data,
    output logic                       in_ready,
    output logic [D-1:0]               out_valid,
    output logic [W*D-1:0]             out_data,
    input  logic [$clog2(D+1)-1:0]     out_take,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(K+1);
    localparam int TW = $clog2(D+1);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [CW-1:0] push;
    logic [TW-1:0] avail, pop;

    assign in_ready = count_q <= NW'(DEPTH - K);
    assign push     = (in_valid && in_ready) ? in_cnt : '0;
    assign count    = count_q;

`ifdef GS232C_FETCH_BUF_BYPASS_EN
    logic [NW-1:0] total;
    assign total = count_q + NW'(push);
    assign avail = reset ? '0 : (total < NW'(D) ? TW'(total) : TW'(D));
`else
    assign avail = count_q < NW'(D) ? TW'(count_q) : TW'(D);
`endif

    assign pop = out_take < avail ? out_take : avail;

    // Next pointer/occupancy state; flush wins over any same-cycle push or pop.
    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = flush ? '0 : count_q + NW'(push) - NW'(pop);
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage writes; every accepted word is stored even if bypassed and consumed at once.
    always_ff @(posedge clk) begin
        for (int j = 0; j < K; j++)
            if (!flush && CW'(j) < push)
                mem[wr_ptr_q + AW'(j)] <= in_data[j*W +: W];
    end

    // Decode slots: oldest words first, invalid slots driven to zero.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int j = 0; j < D; j++) begin
            out_valid[j] = TW'(j) < avail;
            out_data[j*W +: W] = mem[rd_ptr_q + AW'(j)];
`ifdef GS232C_FETCH_BUF_BYPASS_EN
            if (j - int'(count_q) >= 0 && j - int'(count_q) < K)
                out_data[j*W +: W] = in_data[(j - int'(count_q))*W +: W];
`endif
            if (!out_valid[j])
                out_data[j*W +: W] = '0;
        end
    end
endmodule

// File: tb/tb_gs232c_fetch_buf.sv
// tb_gs232c_fetch_buf: table-driven, directed and randomized checks against a queue model.
module tb_gs232c_fetch_buf;
    localparam int W = 32, K = 4, D = 2, DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready;
    logic [2:0]   in_cnt;
    logic [127:0] in_data;
    logic [1:0]   out_valid, out_take;
    logic [63:0]  out_data;
    logic [3:0]   count;

    gs232c_fetch_buf #(.W(W), .K(K), .D(D), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_cnt(in_cnt),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [31:0] q[$];

    typedef struct {
        logic         f, v;
        logic [2:0]   c;
        logic [127:0] d;
        logic [1:0]   t;
        logic [1:0]   ev;
        logic [63:0]  ed;
        logic [3:0]   ecnt;
        logic         erdy;
    } row_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [2:0] c,
                         input logic [127:0] d, input logic [1:0] t);
        flush = f; in_valid = v; in_cnt = c; in_data = d; out_take = t;
    endtask

    // Checks outputs against the queue model, then advances one edge and updates the model.
    task automatic cycle();
        int push, avail, npop;
        logic [31:0] pres[$];
        logic [1:0]  ev;
        logic [63:0] ed;
        #1;
        push = (in_valid && q.size() <= DEPTH - K) ? int'(in_cnt) : 0;
        pres = q;
`ifdef GS232C_FETCH_BUF_BYPASS_EN
        for (int j = 0; j < push; j++) pres.push_back(in_data[j*32 +: 32]);
`endif
        avail = pres.size() < D ? pres.size() : D;
        ev = '0; ed = '0;
        for (int j = 0; j < avail; j++) begin
            ev[j] = 1'b1;
            ed[j*32 +: 32] = pres[j];
        end
        chk("m_count", count, q.size());
        chk("m_ready", in_ready, q.size() <= DEPTH - K);
        chk("m_valid", out_valid, ev);
        chk("m_data", out_data, ed);
        npop = int'(out_take) < avail ? int'(out_take) : avail;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            for (int j = 0; j < push; j++) q.push_back(in_data[j*32 +: 32]);
            repeat (npop) void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    row_t rows[11];
    logic [31:0] seq;

    initial begin
        rows[0]  = '{0, 0, 0, 128'h0, 0, 2'b00, 64'h0, 0, 1};
        rows[1]  = '{0, 1, 4, {32'h13, 32'h12, 32'h11, 32'h10}, 0, 2'b00, 64'h0, 0, 1};
        rows[2]  = '{0, 1, 4, {32'h17, 32'h16, 32'h15, 32'h14}, 0, 2'b11, {32'h11, 32'h10}, 4, 1};
        rows[3]  = '{0, 1, 4, {32'h23, 32'h22, 32'h21, 32'h20}, 0, 2'b11, {32'h11, 32'h10}, 8, 0};
        rows[4]  = '{0, 0, 0, 128'h0, 2, 2'b11, {32'h11, 32'h10}, 8, 0};
        rows[5]  = '{0, 0, 0, 128'h0, 0, 2'b11, {32'h13, 32'h12}, 6, 0};
        rows[6]  = '{1, 1, 4, {32'h33, 32'h32, 32'h31, 32'h30}, 2, 2'b11, {32'h13, 32'h12}, 6, 0};
        rows[7]  = '{0, 0, 0, 128'h0, 0, 2'b00, 64'h0, 0, 1};
        rows[8]  = '{0, 1, 1, {96'h0, 32'h40}, 0, 2'b00, 64'h0, 0, 1};
        rows[9]  = '{0, 0, 0, 128'h0, 2, 2'b01, {32'h0, 32'h40}, 1, 1};
        rows[10] = '{0, 0, 0, 128'h0, 0, 2'b00, 64'h0, 0, 1};

        reset = 1'b1;
        drive(0, 0, 0, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(rows[i].f, rows[i].v, rows[i].c, rows[i].d, rows[i].t);
`ifndef GS232C_FETCH_BUF_BYPASS_EN
            #1;
            chk($sformatf("row%0d_valid", i), out_valid, rows[i].ev);
            chk($sformatf("row%0d_data", i), out_data, rows[i].ed);
            chk($sformatf("row%0d_count", i), count, rows[i].ecnt);
            chk($sformatf("row%0d_ready", i), in_ready, rows[i].erdy);
`endif
            cycle();
        end

        drive(0, 1, 4, {32'h53, 32'h52, 32'h51, 32'h50}, 0); cycle();
        drive(0, 1, 1, {96'h0, 32'h54}, 0); cycle();
        drive(0, 0, 0, '0, 0);
        #1;
        chk("mid_count_before", count, 5);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        cycle();

        drive(0, 1, 3, {32'h0, 32'hA2, 32'hA1, 32'hA0}, 2);
        #1;
`ifdef GS232C_FETCH_BUF_BYPASS_EN
        chk("byp_valid", out_valid, 2'b11);
        chk("byp_data", out_data, {32'hA1, 32'hA0});
`else
        chk("byp_valid", out_valid, 2'b00);
`endif
        cycle();
        drive(0, 0, 0, '0, 0);
        #1;
`ifdef GS232C_FETCH_BUF_BYPASS_EN
        chk("byp_next_count", count, 1);
        chk("byp_next_data", out_data, {32'h0, 32'hA2});
`else
        chk("byp_next_count", count, 3);
        chk("byp_next_data", out_data, {32'hA1, 32'hA0});
`endif
        cycle();

        drive(1, 0, 0, '0, 0); cycle();
        seq = 32'h100;
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, 3, {32'h0, seq + 32'd2, seq + 32'd1, seq}, 2);
            if (q.size() <= DEPTH - K) seq += 32'd3;
            cycle();
        end

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, 1'($urandom), 3'($urandom_range(0, K)),
                  {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, D)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gs232c_fetch_buf.md
# gs232c_fetch_buf

Instruction fetch buffer sitting directly downstream of the k-word selector. Each cycle it accepts up to K consecutive instruction words (the selector's output plus a valid count), holds them in a circular queue, and presents up to D oldest words per cycle to decode. It absorbs the mismatch between fetch bandwidth and decode bandwidth, and is cleared on redirect (flush).

## Interface
Parameters:
- `W`, 32, instruction word width.
- `K`, 4, maximum words accepted per cycle; matches the selector's k.
- `D`, 2, decode slots presented per cycle.
- `DEPTH`, 8, queue entries. Must be a power of two and satisfy DEPTH >= K + D.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all buffered words (pipeline redirect).
- `in_valid`  in  1  `in_data`/`in_cnt` present a fetch group.
- `in_cnt`  in  clog2(K+1)  number of valid words in the group, 0..K; word 0 is the oldest.
- `in_data`  in  W*K  word j at bits [j*W +: W]; same packing as the selector output.
- `in_ready`  out  1  buffer can accept a full K-word group this cycle.
- `out_valid`  out  D  thermometer code; bit j set means slot j holds a word.
- `out_data`  out  W*D  slot j at [j*W +: W]; slot 0 is the oldest word.
- `out_take`  in  clog2(D+1)  number of slots consumed this cycle (from slot 0 upward).
- `count`  out  clog2(DEPTH+1)  number of buffered words (registered).

## Operation
State:
- `mem[DEPTH]` of W bits; not reset.
- `rd_ptr`, `wr_ptr`: log2(DEPTH) bits each, wrap modulo DEPTH.
- `count` register.

Push:
- push = in_valid & in_ready ? in_cnt : 0.
- Word j (j < push) is written to mem[(wr_ptr+j) mod DEPTH].
- wr_ptr advances by push.
- in_cnt = 0 with in_valid is a no-op. in_cnt > K is illegal.

Ready:
- in_ready = (DEPTH - count) >= K, decoded from the registered count only.
- There is no partial acceptance: either the whole group is taken or none of it.

Present:
- Slot j shows mem[(rd_ptr+j) mod DEPTH]. out_valid[j] = (j < avail).
- Without bypass, avail = min(count, D).
- out_data of invalid slots is forced to 0.

Pop:
- pop = min(out_take, popcount(out_valid)); an excess take is clipped and has no other effect.
- rd_ptr advances by pop.

Count:
- count_next = count + push - pop.
- Simultaneous push and pop are legal in the same cycle, including when count = 0 (bypass build) or count = DEPTH - K.

Flush:
- Highest priority. On the next edge rd_ptr, wr_ptr and count become 0.
- Same-cycle push and pop are discarded.
- Because of flush priority, in_ready = 1 on the following cycle.

Reset:
- Asynchronous reset clears rd_ptr, wr_ptr and count.
- Outputs while in reset and after reset: out_valid = 0, out_data = 0, count = 0, in_ready = 1.
- Reset asserted mid-operation drops all buffered words immediately.

## Timing
- in_ready and count are functions of registers only; no combinational path from any input.
- Without bypass:
  - A word pushed at edge t appears in out_valid in the cycle after t, i.e. 1-cycle latency.
  - out_valid and out_data depend only on registers.
- With bypass: see Configuration.
- out_take is sampled at the edge; the consumer may derive it combinationally from out_valid.
- Wrap-around: pointer arithmetic is modulo DEPTH. A group may straddle entry DEPTH-1 to entry 0, and decode slots may straddle the same boundary.

## Configuration
`GS232C_FETCH_BUF_BYPASS_EN`
- Defined: the presented sequence is the buffered words followed by the accepted incoming words.
  - Slot j with j >= count shows in_data word (j - count) when in_valid & in_ready.
  - avail = min(count + push, D).
  - This gives 0-cycle latency when the buffer is nearly empty.
  - It creates a combinational path from in_valid, in_cnt and in_data to out_valid and out_data.
  - Words that are not taken are stored as normal.
- Undefined: no input-to-output combinational path; the minimum latency is 1 cycle.

## Test plan
- Reset, then idle: out_valid = 0, count = 0, in_ready = 1. Reset held mid-stream with count = 5: outputs return to reset values the same cycle.
- Push 4 words 0x10..0x13 with out_take = 0, then push 4 more:
  - count = 8, in_ready = 0.
  - A third push is ignored.
  - out_data slots show 0x10 and 0x11.
- Steady stream, in_cnt = 3 per cycle, out_take = 2:
  - in_ready drops when count > 4.
  - No word is lost or duplicated across the DEPTH-1 to 0 wrap.
  - The output order equals the input order.
- flush asserted together with in_valid (in_cnt = 4) and out_take = 2 at count = 6: next cycle count = 0, out_valid = 0, in_ready = 1.
- out_take = 2 while out_valid = 01: pop = 1, count decrements by exactly 1.
- Bypass build, empty buffer, push in_cnt = 3 of 0xA0..0xA2 with out_take = 2:
  - Same-cycle out_valid = 11, slots show 0xA0 and 0xA1.
  - Next cycle count = 1, slot 0 shows 0xA2.
  - Non-bypass build: out_valid = 00 in the push cycle.
